// File: rtl/branch_predict_ctrl.sv
// Bimodal 2-bit branch predictor with EX-stage resolve,
// one-cycle registered flush/redirect and branch statistics.
module branch_predict_ctrl #(
  parameter int IDX_BITS = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IF_PC,
  output logic        PRED_TAKEN,
  input  logic        EX_VALID,
  input  logic        EX_IS_BRANCH,
  input  logic [2:0]  EX_FUNC3,
  input  logic [31:0] EX_PC,
  input  logic [31:0] EX_TARGET,
  input  logic        EX_PRED_TAKEN,
  input  logic        BR_EQ,
  input  logic        BR_LT,
  input  logic        BR_LTU,
  input  logic        STALL,
  output logic        FLUSH,
  output logic [31:0] REDIRECT_PC,
  output logic [15:0] BR_CNT,
  output logic [15:0] MISS_CNT
);

  localparam int N = 2 ** IDX_BITS;

  typedef enum logic {
    RUN,
    FLUSHING
  } state_t;

  state_t state, state_nxt;

  logic [1:0] tbl [N];

  logic [IDX_BITS-1:0] rd_idx;
  logic [IDX_BITS-1:0] wr_idx;
  logic                resolve;
  logic                taken;
  logic                legal;
  logic                mispredict;
  logic [31:0]         redirect_nxt;
  logic                if_pc_unused;

  assign rd_idx       = IF_PC[IDX_BITS+1:2];
  assign wr_idx       = EX_PC[IDX_BITS+1:2];
  assign if_pc_unused = ^{IF_PC[31:IDX_BITS+2], IF_PC[1:0]};

  // no bypass: IF sees the pre-update counter on a same-edge write
  assign PRED_TAKEN = tbl[rd_idx][1];

  assign FLUSH   = (state == FLUSHING);
  assign resolve = EX_VALID & EX_IS_BRANCH & ~STALL & ~FLUSH;

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (EX_FUNC3)
      3'b000:  taken = BR_EQ;
      3'b001:  taken = ~BR_EQ;
      3'b100:  taken = BR_LT;
      3'b101:  taken = ~BR_LT;
      3'b110:  taken = BR_LTU;
      3'b111:  taken = ~BR_LTU;
      default: legal = 1'b0;
    endcase
  end

  assign mispredict   = resolve & (taken != EX_PRED_TAKEN);
  assign redirect_nxt = taken ? EX_TARGET : EX_PC + 32'd4;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (mispredict) state_nxt = FLUSHING;
      FLUSHING: state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= RUN;
      REDIRECT_PC <= 32'd0;
    end else begin
      state <= state_nxt;
      if (mispredict) REDIRECT_PC <= redirect_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      BR_CNT   <= 16'd0;
      MISS_CNT <= 16'd0;
    end else begin
      if (resolve && BR_CNT != 16'hFFFF)
        BR_CNT <= BR_CNT + 16'd1;
      if (mispredict && MISS_CNT != 16'hFFFF)
        MISS_CNT <= MISS_CNT + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N; i++) tbl[i] <= 2'b01;
    end else if (resolve && legal) begin
      if (taken && tbl[wr_idx] != 2'b11)
        tbl[wr_idx] <= tbl[wr_idx] + 2'b01;
      else if (!taken && tbl[wr_idx] != 2'b00)
        tbl[wr_idx] <= tbl[wr_idx] - 2'b01;
    end
  end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl.
// Inputs change 1ns after a rising edge; outputs are checked there.
module tb_branch_predict_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IF_PC;
  logic        PRED_TAKEN;
  logic        EX_VALID;
  logic        EX_IS_BRANCH;
  logic [2:0]  EX_FUNC3;
  logic [31:0] EX_PC;
  logic [31:0] EX_TARGET;
  logic        EX_PRED_TAKEN;
  logic        BR_EQ;
  logic        BR_LT;
  logic        BR_LTU;
  logic        STALL;
  logic        FLUSH;
  logic [31:0] REDIRECT_PC;
  logic [15:0] BR_CNT;
  logic [15:0] MISS_CNT;

  int checks   = 0;
  int failures = 0;

  branch_predict_ctrl #(.IDX_BITS(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .IF_PC         (IF_PC),
    .PRED_TAKEN    (PRED_TAKEN),
    .EX_VALID      (EX_VALID),
    .EX_IS_BRANCH  (EX_IS_BRANCH),
    .EX_FUNC3      (EX_FUNC3),
    .EX_PC         (EX_PC),
    .EX_TARGET     (EX_TARGET),
    .EX_PRED_TAKEN (EX_PRED_TAKEN),
    .BR_EQ         (BR_EQ),
    .BR_LT         (BR_LT),
    .BR_LTU        (BR_LTU),
    .STALL         (STALL),
    .FLUSH         (FLUSH),
    .REDIRECT_PC   (REDIRECT_PC),
    .BR_CNT        (BR_CNT),
    .MISS_CNT      (MISS_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pred(input string tag,
                      input logic [31:0] pc,
                      input logic exp);
    IF_PC = pc;
    #1;
    chk(tag, {31'd0, PRED_TAKEN}, {31'd0, exp});
  endtask

  task automatic br(input logic [31:0] pc,
                    input logic [31:0] tgt,
                    input logic [2:0] f3,
                    input logic p);
    EX_VALID      = 1'b1;
    EX_IS_BRANCH  = 1'b1;
    EX_PC         = pc;
    EX_TARGET     = tgt;
    EX_FUNC3      = f3;
    EX_PRED_TAKEN = p;
  endtask

  task automatic cnts(input string tag,
                      input logic [15:0] b,
                      input logic [15:0] m);
    chk({tag, "_br"}, {16'd0, BR_CNT}, {16'd0, b});
    chk({tag, "_miss"}, {16'd0, MISS_CNT}, {16'd0, m});
  endtask

  initial begin
    RST = 1'b1;
    IF_PC = 32'd0;
    BR_EQ = 1'b1;
    BR_LT = 1'b0;
    BR_LTU = 1'b0;
    STALL = 1'b0;
    br(32'h100, 32'h200, 3'b000, 1'b0);

    // reset held two cycles with a would-be mispredict in EX
    step();
    step();
    chk("rst_flush", {31'd0, FLUSH}, 32'd0);
    chk("rst_redir", REDIRECT_PC, 32'd0);
    cnts("rst", 16'd0, 16'd0);
    for (int i = 0; i < 16; i++)
      pred($sformatf("rst_pred_%0d", i), 32'(i * 4), 1'b0);
    RST = 1'b0;
    EX_VALID = 1'b0;
    step();
    chk("idle_flush", {31'd0, FLUSH}, 32'd0);

    // BEQ taken, predicted NT
    br(32'h100, 32'h200, 3'b000, 1'b0);
    BR_EQ = 1'b1;
    step();
    EX_VALID = 1'b0;
    chk("beq_flush", {31'd0, FLUSH}, 32'd1);
    chk("beq_redir", REDIRECT_PC, 32'h200);
    cnts("beq", 16'd1, 16'd1);
    step();
    chk("beq_flush_end", {31'd0, FLUSH}, 32'd0);
    pred("beq_pred", 32'h100, 1'b1);

    // three correct taken resolutions: 10 -> 11 -> 11 -> 11
    for (int i = 0; i < 3; i++) begin
      br(32'h100, 32'h200, 3'b000, 1'b1);
      step();
      chk($sformatf("sat_t_flush_%0d", i), {31'd0, FLUSH}, 32'd0);
    end
    EX_VALID = 1'b0;
    cnts("sat_t", 16'd4, 16'd1);
    pred("sat_t_pred", 32'h100, 1'b1);

    // not taken x3: 11 -> 10 -> 01 -> 00
    BR_EQ = 1'b0;
    br(32'h100, 32'h200, 3'b000, 1'b1);
    step();
    EX_VALID = 1'b0;
    chk("nt1_flush", {31'd0, FLUSH}, 32'd1);
    chk("nt1_redir", REDIRECT_PC, 32'h104);
    pred("nt1_pred", 32'h100, 1'b1);
    step();
    br(32'h100, 32'h200, 3'b000, 1'b0);
    step();
    EX_VALID = 1'b0;
    chk("nt2_flush", {31'd0, FLUSH}, 32'd0);
    pred("nt2_pred", 32'h100, 1'b0);
    br(32'h100, 32'h200, 3'b000, 1'b1);
    step();
    EX_VALID = 1'b0;
    chk("nt3_flush", {31'd0, FLUSH}, 32'd1);
    step();
    chk("nt3_flush_end", {31'd0, FLUSH}, 32'd0);
    pred("nt3_pred", 32'h100, 1'b0);
    cnts("sat_nt", 16'd7, 16'd3);

    // BGE not taken (BR_LT=1), predicted taken, PC+4 wraps
    BR_LT = 1'b1;
    br(32'hFFFF_FFFC, 32'h1000, 3'b101, 1'b1);
    step();
    chk("bge_flush", {31'd0, FLUSH}, 32'd1);
    chk("bge_redir", REDIRECT_PC, 32'h0);
    cnts("bge", 16'd8, 16'd4);

    // wrong-path mispredicting branch sitting in the flush cycle
    BR_EQ = 1'b1;
    br(32'h208, 32'h300, 3'b000, 1'b0);
    step();
    EX_VALID = 1'b0;
    chk("shadow_flush", {31'd0, FLUSH}, 32'd0);
    cnts("shadow", 16'd8, 16'd4);
    pred("shadow_pred", 32'h208, 1'b0);

    // mispredicting branch held under stall, then released
    br(32'h10C, 32'h400, 3'b000, 1'b0);
    STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_flush_%0d", i), {31'd0, FLUSH}, 32'd0);
    end
    cnts("stall", 16'd8, 16'd4);
    STALL = 1'b0;
    step();
    EX_VALID = 1'b0;
    chk("unstall_flush", {31'd0, FLUSH}, 32'd1);
    chk("unstall_redir", REDIRECT_PC, 32'h400);
    cnts("unstall", 16'd9, 16'd5);
    step();
    pred("unstall_pred", 32'h10C, 1'b1);

    // illegal func3: taken=0, no table write
    br(32'h40, 32'h800, 3'b010, 1'b1);
    step();
    EX_VALID = 1'b0;
    chk("ill_flush", {31'd0, FLUSH}, 32'd1);
    chk("ill_redir", REDIRECT_PC, 32'h44);
    cnts("ill", 16'd10, 16'd6);
    step();
    br(32'h44, 32'h800, 3'b011, 1'b1);
    step();
    EX_VALID = 1'b0;
    chk("ill2_redir", REDIRECT_PC, 32'h48);
    cnts("ill2", 16'd11, 16'd7);
    step();
    pred("ill2_pred", 32'h44, 1'b0);

    // reset during a flush
    BR_EQ = 1'b1;
    br(32'h80, 32'h900, 3'b000, 1'b0);
    step();
    EX_VALID = 1'b0;
    chk("mid_flush", {31'd0, FLUSH}, 32'd1);
    RST = 1'b1;
    step();
    chk("mid_rst_flush", {31'd0, FLUSH}, 32'd0);
    chk("mid_rst_redir", REDIRECT_PC, 32'd0);
    cnts("mid_rst", 16'd0, 16'd0);
    pred("mid_rst_pred", 32'h10C, 1'b0);
    RST = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
